// File: rtl/wb_stage_mc_pkg.sv
// Shared constants and MEM->WB bus layout helpers for the registered write-back stage.
// Bus layout, MSB first: {is_mul, wdest[AW], we, result[DW], dm_addr[DW], pc[PCW]}.
package wb_stage_mc_pkg;

    localparam int WAIT_W  = 4;
    localparam int R0_ADDR = 0;

    function automatic int mem2wb_bus_w(input int dw, input int aw, input int pcw);
        return 2 + aw + 2 * dw + pcw;
    endfunction

    function automatic int off_dm_addr(input int pcw);
        return pcw;
    endfunction

    function automatic int off_result(input int dw, input int pcw);
        return pcw + dw;
    endfunction

    function automatic int off_we(input int dw, input int pcw);
        return pcw + 2 * dw;
    endfunction

    function automatic int off_wdest(input int dw, input int pcw);
        return pcw + 2 * dw + 1;
    endfunction

    function automatic int off_is_mul(input int dw, input int aw, input int pcw);
        return pcw + 2 * dw + 1 + aw;
    endfunction

endpackage

// File: rtl/wb_wait_ctr.sv
// Occupancy bit plus wait down-counter for the WB stage register.
// An entry is ready once its counter has reached zero.
module wb_wait_ctr
    import wb_stage_mc_pkg::*;
#(
    parameter int W = WAIT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         flush,
    output logic         valid,
    output logic         ready
);

    logic         vld_q;
    logic [W-1:0] cnt_q;

    // load wins over flush so a commit can be followed by a capture on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else if (load) begin
            vld_q <= 1'b1;
            cnt_q <= load_val;
        end else if (flush) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
        end else if (dec && cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign valid = vld_q;
    assign ready = vld_q & (cnt_q == '0);

endmodule

// File: rtl/wb_stage_mc.sv
// Registered write-back stage: one-entry MEM->WB register, multiply wait,
// r0 write suppression, flush, forwarding to ID and a retired-instruction counter.
module wb_stage_mc
    import wb_stage_mc_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int PCW     = 32,
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 32,
    parameter int BUS_W   = 2 + AW + 2 * DW + PCW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem2wb_valid_i,
    input  logic [BUS_W-1:0] mem2wb_bus_i,
    output logic             wb_allowin_o,
    input  logic             flush_i,
    input  logic [DW-1:0]    mult_P_i,
    output logic             rf_we_o,
    output logic [AW-1:0]    rf_wdest_o,
    output logic [DW-1:0]    rf_wdata_o,
    output logic             fwd_valid_o,
    output logic [AW-1:0]    fwd_dest_o,
    output logic [DW-1:0]    fwd_data_o,
    output logic             fwd_ready_o,
    output logic             ctl_wb_over_o,
    output logic [PCW-1:0]   ctl_wb_pc_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam int O_DMA  = off_dm_addr(PCW);
    localparam int O_RES  = off_result(DW, PCW);
    localparam int O_WE   = off_we(DW, PCW);
    localparam int O_DEST = off_wdest(DW, PCW);
    localparam int O_MUL  = off_is_mul(DW, AW, PCW);
    localparam logic [WAIT_W-1:0] MUL_CNT = WAIT_W'(MUL_LAT);
    localparam logic [AW-1:0]     R0      = AW'(R0_ADDR);

    logic              q_is_mul, q_we;
    logic [AW-1:0]     q_dest;
    logic [DW-1:0]     q_res;
    logic [PCW-1:0]    q_pc;
    logic [CNT_W-1:0]  ret_q;
    logic              valid, ready, commit, load, clear, wr_dest, in_mul;
    logic [DW-1:0]     wdata;
    logic              unused_dm_addr;

    // data-memory address travels on the bus but is not needed after MEM
    assign unused_dm_addr = ^mem2wb_bus_i[O_DMA +: DW];

    assign in_mul       = mem2wb_bus_i[O_MUL];
    assign commit       = ready;
    assign wb_allowin_o = ~valid | commit;
    assign load         = mem2wb_valid_i & wb_allowin_o & ~flush_i;
    assign clear        = commit | (flush_i & valid);

    wb_wait_ctr #(.W(WAIT_W)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (in_mul ? MUL_CNT : '0),
        .dec      (valid),
        .flush    (clear),
        .valid    (valid),
        .ready    (ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_is_mul <= 1'b0;
            q_we     <= 1'b0;
            q_dest   <= '0;
            q_res    <= '0;
            q_pc     <= '0;
        end else if (load) begin
            q_is_mul <= in_mul;
            q_we     <= mem2wb_bus_i[O_WE];
            q_dest   <= mem2wb_bus_i[O_DEST +: AW];
            q_res    <= mem2wb_bus_i[O_RES +: DW];
            q_pc     <= mem2wb_bus_i[PCW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ret_q <= '0;
        else if (commit)
            ret_q <= ret_q + CNT_W'(1);
    end

    // product is only final in the commit cycle, so it is taken straight from the port
    assign wdata   = q_is_mul ? mult_P_i : q_res;
    assign wr_dest = q_we & (q_dest != R0);

    assign rf_we_o       = commit & wr_dest;
    assign rf_wdest_o    = commit ? q_dest : '0;
    assign rf_wdata_o    = commit ? wdata : '0;
    assign fwd_valid_o   = valid & wr_dest;
    assign fwd_dest_o    = fwd_valid_o ? q_dest : '0;
    assign fwd_ready_o   = fwd_valid_o & ready;
    assign fwd_data_o    = fwd_ready_o ? wdata : '0;
    assign ctl_wb_over_o = commit;
    assign ctl_wb_pc_o   = valid ? q_pc : '0;
    assign retire_cnt_o  = ret_q;

endmodule
